pes_rtc_alarm: RTL and testbench

Parametrised real-time clock with a seconds prescaler, selectable 12/24-hour mode, synchronous time load, and a minute-resolution alarm. It keeps time as six BCD digits (hh:mm:ss), advances once per prescaled second, and raises a sticky alarm flag for the interrupt/LED logic downstream. It is the drop-in successor to the free-running per-cycle RTC in the display path.

---
 rtl/pes_rtc_pkg.sv | 41 ++++
 rtl/pes_rtc_alarm_bcd_digit_ctr.sv | 28 ++
 rtl/pes_rtc_alarm.sv | 119 +++++++++++
 tb/tb_pes_rtc_alarm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pes_rtc_pkg.sv
// Shared types, limits and helpers for the BCD real-time clock.
package pes_rtc_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd_byte_t;

  localparam bcd_t        DIGIT_MAX  = 4'd9;
  localparam bcd_t        TENS_MAX   = 4'd5;
  localparam int unsigned HR24_MAX   = 23;
  localparam int unsigned HR12_MAX   = 12;

  function automatic logic is_bcd(bcd_byte_t v);
    return (v.tens <= DIGIT_MAX) && (v.units <= DIGIT_MAX);
  endfunction

  function automatic int unsigned bcd_val(bcd_byte_t v);
    return int'(v.tens) * 10 + int'(v.units);
  endfunction

  // Hours span 00-23 in 24h mode and 01-12 in 12h mode.
  function automatic logic valid_time(bcd_byte_t hr, bcd_byte_t min, bcd_byte_t sec, logic h12);
    logic ok;
    ok = is_bcd(hr) && is_bcd(min) && is_bcd(sec) &&
         (min.tens <= TENS_MAX) && (sec.tens <= TENS_MAX);
    if (h12) ok = ok && (bcd_val(hr) >= 1) && (bcd_val(hr) <= HR12_MAX);
    else     ok = ok && (bcd_val(hr) <= HR24_MAX);
    return ok;
  endfunction

  function automatic bcd_byte_t bcd_inc(bcd_byte_t v);
    bcd_byte_t r;
    if (v.units == DIGIT_MAX) r = '{tens: v.tens + 4'd1, units: 4'd0};
    else                      r = '{tens: v.tens, units: v.units + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/pes_rtc_alarm_bcd_digit_ctr.sv
// Single BCD digit counter wrapping at MAX; load beats clear beats count.
module bcd_digit_ctr
  import pes_rtc_pkg::*;
#(
  parameter bcd_t MAX     = DIGIT_MAX,
  parameter bcd_t RST_VAL = 4'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t count,
  output logic carry
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= RST_VAL;
    else if (ld)    count <= ld_val;
    else if (clr)   count <= 4'd0;
    else if (en)    count <= (count == MAX) ? 4'd0 : count + 4'd1;
  end

  assign carry = en && (count == MAX);

endmodule

// File: rtl/pes_rtc_alarm.sv
// BCD hh:mm:ss real-time clock with prescaler, 12/24h mode, validated load and sticky alarm.
module pes_rtc_alarm
  import pes_rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter bit          H12     = 1'b0
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] ld_hr,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  input  logic       ld_pm,
  input  logic       alm_wr,
  input  logic [7:0] alm_hr,
  input  logic [7:0] alm_min,
  input  logic       alm_pm,
  input  logic       alm_arm,
  input  logic       alm_ack,
  output logic [3:0] hrm,
  output logic [3:0] hrl,
  output logic [3:0] minm,
  output logic [3:0] minl,
  output logic [3:0] secm,
  output logic [3:0] secl,
  output logic       pm,
  output logic       tick,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned    PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PS_TERM = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          load_ok, tick_int, alm_match;
  logic          secl_c, secm_c, minl_c, minm_c, hrl_c, hrm_c;
  logic          hr_at_wrap, hr_ld;
  bcd_byte_t     hr_b, min_b, sec_b, hr_wrap_val, hr_next, hr_ld_val;
  bcd_byte_t     nxt_hr, nxt_min, alm_hr_q, alm_min_q;
  logic          nxt_pm, alm_pm_q;

  assign hr_b  = '{tens: hrm,  units: hrl};
  assign min_b = '{tens: minm, units: minl};
  assign sec_b = '{tens: secm, units: secl};

  assign load_ok  = load && valid_time(bcd_byte_t'(ld_hr), bcd_byte_t'(ld_min),
                                       bcd_byte_t'(ld_sec), H12);
  assign tick_int = run && (presc == PS_TERM) && !load_ok;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst)         presc <= '0;
    else if (load_ok) presc <= '0;
    else if (run)     presc <= (presc == PS_TERM) ? '0 : presc + 1'b1;
  end

  // Hour wraps are irregular in BCD, so they are loaded rather than counted.
  assign hr_at_wrap  = H12 ? ((hr_b == 8'h11) || (hr_b == 8'h12)) : (hr_b == 8'h23);
  assign hr_wrap_val = !H12 ? 8'h00 : ((hr_b == 8'h11) ? 8'h12 : 8'h01);
  assign hr_next     = hr_at_wrap ? hr_wrap_val : bcd_inc(hr_b);
  assign hr_ld       = load_ok || (minm_c && hr_at_wrap);
  assign hr_ld_val   = load_ok ? bcd_byte_t'(ld_hr) : hr_wrap_val;

  bcd_digit_ctr #(.MAX(4'd9)) u_secl (
    .clk(clkin), .rst(rst), .en(tick_int), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_sec[3:0]), .count(secl), .carry(secl_c));
  bcd_digit_ctr #(.MAX(4'd5)) u_secm (
    .clk(clkin), .rst(rst), .en(secl_c), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_sec[7:4]), .count(secm), .carry(secm_c));
  bcd_digit_ctr #(.MAX(4'd9)) u_minl (
    .clk(clkin), .rst(rst), .en(secm_c), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_min[3:0]), .count(minl), .carry(minl_c));
  bcd_digit_ctr #(.MAX(4'd5)) u_minm (
    .clk(clkin), .rst(rst), .en(minl_c), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_min[7:4]), .count(minm), .carry(minm_c));
  // A tens-of-hours overflow is unreachable from valid states; it clears as a guard.
  bcd_digit_ctr #(.MAX(4'd9), .RST_VAL(H12 ? 4'd2 : 4'd0)) u_hrl (
    .clk(clkin), .rst(rst), .en(minm_c && !hr_at_wrap), .clr(hrm_c), .ld(hr_ld),
    .ld_val(hr_ld_val.units), .count(hrl), .carry(hrl_c));
  bcd_digit_ctr #(.MAX(H12 ? 4'd1 : 4'd2), .RST_VAL(H12 ? 4'd1 : 4'd0)) u_hrm (
    .clk(clkin), .rst(rst), .en(hrl_c), .clr(hrm_c), .ld(hr_ld),
    .ld_val(hr_ld_val.tens), .count(hrm), .carry(hrm_c));

  // Time as it will read after this advance; only meaningful when seconds are 59.
  assign nxt_min = (min_b == 8'h59) ? 8'h00 : bcd_inc(min_b);
  assign nxt_hr  = (min_b == 8'h59) ? hr_next : hr_b;
  assign nxt_pm  = pm ^ (H12 && (min_b == 8'h59) && (hr_b == 8'h11));

  assign alm_match = tick_int && alm_arm && (sec_b == 8'h59) &&
                     (nxt_min == alm_min_q) && (nxt_hr == alm_hr_q) &&
                     (!H12 || (nxt_pm == alm_pm_q));

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      pm        <= 1'b0;
      tick      <= 1'b0;
      load_err  <= 1'b0;
      alarm     <= 1'b0;
      alm_hr_q  <= '0;
      alm_min_q <= '0;
      alm_pm_q  <= 1'b0;
    end else begin
      tick     <= tick_int;
      load_err <= load && !load_ok;
      if (load_ok)                                 pm <= H12 & ld_pm;
      else if (H12 && minm_c && (hr_b == 8'h11))   pm <= ~pm;
      if (alm_wr) begin
        alm_hr_q  <= bcd_byte_t'(alm_hr);
        alm_min_q <= bcd_byte_t'(alm_min);
        alm_pm_q  <= alm_pm;
      end
      if (alm_match)    alarm <= 1'b1;
      else if (alm_ack) alarm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pes_rtc_alarm.sv
// Directed bench: a 24h/div-4 instance and a 12h/div-1 instance driven side by side.
module tb_pes_rtc_alarm;

  typedef struct packed {
    logic       run;
    logic       load;
    logic [7:0] ld_hr;
    logic [7:0] ld_min;
    logic [7:0] ld_sec;
    logic       ld_pm;
    logic       alm_wr;
    logic [7:0] alm_hr;
    logic [7:0] alm_min;
    logic       alm_pm;
    logic       alm_arm;
    logic       alm_ack;
  } in_t;

  logic        clkin = 1'b0;
  logic        rst;
  in_t         ia, ib;
  logic [23:0] a_t, b_t;
  logic        a_pm, a_tick, a_alarm, a_lerr;
  logic        b_pm, b_tick, b_alarm, b_lerr;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clkin = ~clkin;

  pes_rtc_alarm #(.CLK_DIV(4), .H12(1'b0)) u24 (
    .clkin(clkin), .rst(rst), .run(ia.run), .load(ia.load),
    .ld_hr(ia.ld_hr), .ld_min(ia.ld_min), .ld_sec(ia.ld_sec), .ld_pm(ia.ld_pm),
    .alm_wr(ia.alm_wr), .alm_hr(ia.alm_hr), .alm_min(ia.alm_min), .alm_pm(ia.alm_pm),
    .alm_arm(ia.alm_arm), .alm_ack(ia.alm_ack),
    .hrm(a_t[23:20]), .hrl(a_t[19:16]), .minm(a_t[15:12]), .minl(a_t[11:8]),
    .secm(a_t[7:4]), .secl(a_t[3:0]),
    .pm(a_pm), .tick(a_tick), .alarm(a_alarm), .load_err(a_lerr));

  pes_rtc_alarm #(.CLK_DIV(1), .H12(1'b1)) u12 (
    .clkin(clkin), .rst(rst), .run(ib.run), .load(ib.load),
    .ld_hr(ib.ld_hr), .ld_min(ib.ld_min), .ld_sec(ib.ld_sec), .ld_pm(ib.ld_pm),
    .alm_wr(ib.alm_wr), .alm_hr(ib.alm_hr), .alm_min(ib.alm_min), .alm_pm(ib.alm_pm),
    .alm_arm(ib.alm_arm), .alm_ack(ib.alm_ack),
    .hrm(b_t[23:20]), .hrl(b_t[19:16]), .minm(b_t[15:12]), .minl(b_t[11:8]),
    .secm(b_t[7:4]), .secl(b_t[3:0]),
    .pm(b_pm), .tick(b_tick), .alarm(b_alarm), .load_err(b_lerr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clkin);
  endtask

  task automatic load_a(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic r);
    ia.load = 1'b1; ia.ld_hr = h; ia.ld_min = m; ia.ld_sec = s; ia.run = r;
    step();
    ia.load = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic p, input logic r);
    ib.load = 1'b1; ib.ld_hr = h; ib.ld_min = m; ib.ld_sec = s; ib.ld_pm = p; ib.run = r;
    step();
    ib.load = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ia = '0;
    ib = '0;
    rst = 1'b0;
    step(2);
    check("rst_a_time", a_t, 24'h000000);
    check("rst_a_flags", {a_pm, a_tick, a_alarm, a_lerr}, 4'b0000);
    check("rst_b_time", b_t, 24'h120000);
    check("rst_b_flags", {b_pm, b_tick, b_alarm, b_lerr}, 4'b0000);
    rst = 1'b1;
    step();

    // 24h rollover with a divide-by-4 prescaler
    load_a(8'h23, 8'h59, 8'h58, 1'b1);
    check("ld_time", a_t, 24'h235958);
    check("ld_no_tick", a_tick, 1'b0);
    step(3);
    check("pre_tick_time", a_t, 24'h235958);
    check("pre_tick", a_tick, 1'b0);
    step();
    check("tick1", a_tick, 1'b1);
    check("tick1_time", a_t, 24'h235959);
    step(4);
    check("tick2", a_tick, 1'b1);
    check("wrap24_time", a_t, 24'h000000);
    step();
    check("tick_pulse", a_tick, 1'b0);
    step();
    ia.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_tick", a_tick, 1'b0);
    end
    check("hold_time", a_t, 24'h000000);
    ia.run = 1'b1;
    step();
    check("resume_wait", a_tick, 1'b0);
    step();
    check("resume_tick", a_tick, 1'b1);
    check("resume_time", a_t, 24'h000001);

    // load on the terminal-count cycle beats the tick
    step(3);
    load_a(8'h10, 8'h20, 8'h30, 1'b1);
    check("ld_vs_tick_time", a_t, 24'h102030);
    check("ld_vs_tick", a_tick, 1'b0);
    step(3);
    check("ld_gap", a_tick, 1'b0);
    step();
    check("ld_next_tick", a_tick, 1'b1);
    check("ld_next_time", a_t, 24'h102031);
    ia.run = 1'b0;

    // invalid loads
    load_a(8'h24, 8'h00, 8'h00, 1'b0);
    check("err24_pulse", a_lerr, 1'b1);
    check("err24_time", a_t, 24'h102031);
    step();
    check("err24_once", a_lerr, 1'b0);
    load_a(8'h10, 8'h6A, 8'h00, 1'b0);
    check("err6a_pulse", a_lerr, 1'b1);
    check("err6a_time", a_t, 24'h102031);

    // alarm set, ack, ack collision, arm drop, write on matching edge
    ia.alm_wr = 1'b1; ia.alm_hr = 8'h07; ia.alm_min = 8'h30; ia.alm_arm = 1'b1;
    step();
    ia.alm_wr = 1'b0;
    load_a(8'h07, 8'h30, 8'h00, 1'b0);
    check("load_no_alarm", a_alarm, 1'b0);
    load_a(8'h07, 8'h29, 8'h59, 1'b1);
    step(3);
    check("alarm_early", a_alarm, 1'b0);
    step();
    check("alarm_time", a_t, 24'h073000);
    check("alarm_set", a_alarm, 1'b1);
    ia.run = 1'b0;
    ia.alm_ack = 1'b1;
    step();
    ia.alm_ack = 1'b0;
    check("alarm_ack", a_alarm, 1'b0);
    load_a(8'h07, 8'h29, 8'h59, 1'b1);
    step(2);
    ia.alm_ack = 1'b1;
    step(2);
    ia.alm_ack = 1'b0;
    ia.run = 1'b0;
    check("set_beats_ack", a_alarm, 1'b1);
    ia.alm_arm = 1'b0;
    step();
    check("disarm_keeps", a_alarm, 1'b1);
    ia.alm_arm = 1'b1;
    ia.alm_ack = 1'b1;
    step();
    ia.alm_ack = 1'b0;
    check("alarm_ack2", a_alarm, 1'b0);
    load_a(8'h07, 8'h29, 8'h59, 1'b1);
    step(3);
    ia.alm_wr = 1'b1; ia.alm_hr = 8'h08; ia.alm_min = 8'h00;
    step();
    ia.alm_wr = 1'b0;
    ia.run = 1'b0;
    check("wr_uses_old", a_alarm, 1'b1);

    // 12h mode, advance every cycle
    load_b(8'h11, 8'h59, 8'h59, 1'b0, 1'b1);
    check("h12_ld_time", b_t, 24'h115959);
    check("h12_ld_pm", b_pm, 1'b0);
    step();
    ib.run = 1'b0;
    check("h12_noon_time", b_t, 24'h120000);
    check("h12_noon_pm", b_pm, 1'b1);
    check("h12_tick", b_tick, 1'b1);
    load_b(8'h12, 8'h59, 8'h59, 1'b1, 1'b1);
    check("h12_ld2_time", b_t, 24'h125959);
    step();
    ib.run = 1'b0;
    check("h12_one_time", b_t, 24'h010000);
    check("h12_one_pm", b_pm, 1'b1);
    load_b(8'h00, 8'h30, 8'h00, 1'b0, 1'b0);
    check("h12_err_pulse", b_lerr, 1'b1);
    check("h12_err_time", b_t, 24'h010000);
    step();
    check("h12_err_once", b_lerr, 1'b0);

    // asynchronous reset between edges
    ia.run = 1'b1;
    ib.run = 1'b1;
    step(2);
    @(posedge clkin);
    #2 rst = 1'b0;
    #1;
    check("arst_a_time", a_t, 24'h000000);
    check("arst_a_flags", {a_pm, a_tick, a_alarm, a_lerr}, 4'b0000);
    check("arst_b_time", b_t, 24'h120000);
    check("arst_b_flags", {b_pm, b_tick, b_alarm, b_lerr}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
